// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic lamp monitor: FSM states, fault causes
// and the bit layout of the six-lamp vector.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_MONITOR = 2'd1,
        ST_FAULT   = 2'd2
    } state_e;

    localparam logic [2:0] FC_NONE      = 3'd0;
    localparam logic [2:0] FC_CONFLICT  = 3'd1;
    localparam logic [2:0] FC_INVALID   = 3'd2;
    localparam logic [2:0] FC_CLEARANCE = 3'd3;
    localparam logic [2:0] FC_WATCHDOG  = 3'd4;

    localparam int LAMP_W  = 6;
    localparam int LAMP_R1 = 0;
    localparam int LAMP_Y1 = 1;
    localparam int LAMP_G1 = 2;
    localparam int LAMP_R2 = 3;
    localparam int LAMP_Y2 = 4;
    localparam int LAMP_G2 = 5;

    typedef logic [LAMP_W-1:0] lamp_t;

    localparam lamp_t LAMPS_RED_RED = lamp_t'((1 << LAMP_R1) | (1 << LAMP_R2));

    // A direction is well-formed only when exactly one of its three lamps is lit.
    function automatic logic exactlyOne(input logic r, input logic y, input logic g);
        return ({r, y, g} == 3'b100) || ({r, y, g} == 3'b010) || ({r, y, g} == 3'b001);
    endfunction

endpackage

// File: rtl/traffic_blinker.sv
// Fault flash generator: square wave with a half-period of BLINK_CYCLES,
// starting in the lit phase on the first cycle it is enabled.
module traffic_blinker #(
    parameter int unsigned BLINK_CYCLES = 8_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable_i,
    output logic blink_o
);

    localparam int CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             blink_q;

    // Held preloaded to the lit phase while disabled so entry always starts on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            blink_q <= 1'b1;
        end else if (!enable_i) begin
            cnt_q   <= '0;
            blink_q <= 1'b1;
        end else if (cnt_q == CNT_W'(BLINK_CYCLES - 1)) begin
            cnt_q   <= '0;
            blink_q <= ~blink_q;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign blink_o = blink_q;

endmodule

// File: rtl/traffic_lamp_monitor.sv
// Safety monitor between a traffic light controller and the lamp drivers:
// passes lamp requests through one cycle late and latches a flashing fault on any unsafe pattern.
module traffic_lamp_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_CLEAR_CYCLES = 48,
    parameter int unsigned WATCHDOG_CYCLES  = 1_600_000_000,
    parameter int unsigned BLINK_CYCLES     = 8_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       red1,
    input  logic       yellow1,
    input  logic       green1,
    input  logic       red2,
    input  logic       yellow2,
    input  logic       green2,
    output logic       lamp_red1,
    output logic       lamp_yellow1,
    output logic       lamp_green1,
    output logic       lamp_red2,
    output logic       lamp_yellow2,
    output logic       lamp_green2,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int AR_W = $clog2(MIN_CLEAR_CYCLES + 1);
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

    state_e          state_q;
    lamp_t           lamp_q;
    lamp_t           prev_q;
    logic            fault_q;
    logic [2:0]      faultCode_q;
    logic [AR_W-1:0] initCnt_q;
    logic [AR_W-1:0] allRedCnt_q;
    logic [WD_W-1:0] wdCnt_q;

    lamp_t           inVec;
    logic            conflict;
    logic            invalid;
    logic            clearance;
    logic            watchdog;
    logic [31:0]     holdCount;
    logic [2:0]      detectCode;
    logic [AR_W-1:0] allRedCnt_d;
    logic [WD_W-1:0] wdCnt_d;
    logic            blink;

    always_comb begin
        inVec          = '0;
        inVec[LAMP_R1] = red1;
        inVec[LAMP_Y1] = yellow1;
        inVec[LAMP_G1] = green1;
        inVec[LAMP_R2] = red2;
        inVec[LAMP_Y2] = yellow2;
        inVec[LAMP_G2] = green2;
    end

    // Checks look at the current inputs so an unsafe pattern is caught before it is ever registered onto the lamps.
    always_comb begin
        conflict  = (yellow1 | green1) & (yellow2 | green2);
        invalid   = !exactlyOne(red1, yellow1, green1) || !exactlyOne(red2, yellow2, green2);
        clearance = ((green1 & ~prev_q[LAMP_G1]) | (green2 & ~prev_q[LAMP_G2]))
                    && (32'(allRedCnt_q) < MIN_CLEAR_CYCLES);
        holdCount = (inVec == prev_q) ? 32'(wdCnt_q) + 32'd1 : 32'd1;
        watchdog  = (holdCount >= WATCHDOG_CYCLES);
        wdCnt_d   = WD_W'(holdCount);

        allRedCnt_d = '0;
        if (red1 && red2) begin
            allRedCnt_d = (32'(allRedCnt_q) >= MIN_CLEAR_CYCLES) ? allRedCnt_q
                                                                 : allRedCnt_q + AR_W'(1);
        end

        detectCode = FC_NONE;
        if (conflict)       detectCode = FC_CONFLICT;
        else if (invalid)   detectCode = FC_INVALID;
        else if (clearance) detectCode = FC_CLEARANCE;
        else if (watchdog)  detectCode = FC_WATCHDOG;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            lamp_q      <= LAMPS_RED_RED;
            prev_q      <= '0;
            fault_q     <= 1'b0;
            faultCode_q <= FC_NONE;
            initCnt_q   <= '0;
            allRedCnt_q <= '0;
            wdCnt_q     <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    lamp_q      <= LAMPS_RED_RED;
                    prev_q      <= inVec;
                    allRedCnt_q <= allRedCnt_d;
                    if (32'(initCnt_q) >= MIN_CLEAR_CYCLES - 1) begin
                        state_q   <= ST_MONITOR;
                        initCnt_q <= '0;
                        wdCnt_q   <= '0;
                    end else begin
                        initCnt_q <= initCnt_q + AR_W'(1);
                    end
                end
                ST_MONITOR: begin
                    if (detectCode != FC_NONE) begin
                        state_q     <= ST_FAULT;
                        fault_q     <= 1'b1;
                        faultCode_q <= detectCode;
                        lamp_q      <= '0;
                    end else begin
                        lamp_q      <= inVec;
                        prev_q      <= inVec;
                        allRedCnt_q <= allRedCnt_d;
                        wdCnt_q     <= wdCnt_d;
                    end
                end
                ST_FAULT: begin
                    lamp_q <= '0;
                end
                default: begin
                    state_q <= ST_FAULT;
                end
            endcase
        end
    end

    traffic_blinker #(
        .BLINK_CYCLES(BLINK_CYCLES)
    ) u_blinker (
        .clk     (clk),
        .rst     (rst),
        .enable_i(state_q == ST_FAULT),
        .blink_o (blink)
    );

    assign lamp_red1    = lamp_q[LAMP_R1];
    assign lamp_green1  = lamp_q[LAMP_G1];
    assign lamp_red2    = lamp_q[LAMP_R2];
    assign lamp_green2  = lamp_q[LAMP_G2];
    assign lamp_yellow1 = fault_q ? blink : lamp_q[LAMP_Y1];
    assign lamp_yellow2 = fault_q ? blink : lamp_q[LAMP_Y2];
    assign fault        = fault_q;
    assign fault_code   = faultCode_q;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Directed bench for traffic_lamp_monitor with short timing parameters
// (clearance 3, watchdog 100, flash half-period 4).
module tb_traffic_lamp_monitor;

    // Lamp vectors are written {red1, yellow1, green1, red2, yellow2, green2}.
    localparam logic [5:0] RR       = 6'b100_100;
    localparam logic [5:0] G1R2     = 6'b001_100;
    localparam logic [5:0] Y1R2     = 6'b010_100;
    localparam logic [5:0] R1G2     = 6'b100_001;
    localparam logic [5:0] R1Y2     = 6'b100_010;
    localparam logic [5:0] FLASH_ON = 6'b010_010;
    localparam logic [5:0] DARK     = 6'b000_000;

    logic       clk;
    logic       rst;
    logic       red1, yellow1, green1, red2, yellow2, green2;
    logic       lamp_red1, lamp_yellow1, lamp_green1;
    logic       lamp_red2, lamp_yellow2, lamp_green2;
    logic       fault;
    logic [2:0] fault_code;
    logic [5:0] lampsObs;

    int checks = 0;
    int errors = 0;

    traffic_lamp_monitor #(
        .MIN_CLEAR_CYCLES(3),
        .WATCHDOG_CYCLES (100),
        .BLINK_CYCLES    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .red1        (red1),
        .yellow1     (yellow1),
        .green1      (green1),
        .red2        (red2),
        .yellow2     (yellow2),
        .green2      (green2),
        .lamp_red1   (lamp_red1),
        .lamp_yellow1(lamp_yellow1),
        .lamp_green1 (lamp_green1),
        .lamp_red2   (lamp_red2),
        .lamp_yellow2(lamp_yellow2),
        .lamp_green2 (lamp_green2),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    assign lampsObs = {lamp_red1, lamp_yellow1, lamp_green1, lamp_red2, lamp_yellow2, lamp_green2};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Upstream controller: all-red 3, green 30, yellow 5 per direction, 76-cycle period.
    function automatic logic [5:0] upstreamPattern(input int c);
        int p;
        p = c % 76;
        if (p < 3)       return RR;
        else if (p < 33) return G1R2;
        else if (p < 38) return Y1R2;
        else if (p < 41) return RR;
        else if (p < 71) return R1G2;
        else             return R1Y2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [5:0] v);
        {red1, yellow1, green1, red2, yellow2, green2} = v;
    endtask

    task automatic checkLamps(input string tag, input logic [5:0] expected);
        checks++;
        assert (lampsObs === expected) else begin
            errors++;
            $error("[TB] FAIL %s lamps: observed=%b expected=%b", tag, lampsObs, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [5:0] expLamps,
                               input logic expFault, input logic [2:0] expCode);
        checkLamps(tag, expLamps);
        checks++;
        assert (fault === expFault) else begin
            errors++;
            $error("[TB] FAIL %s fault: observed=%b expected=%b", tag, fault, expFault);
        end
        checks++;
        assert (fault_code === expCode) else begin
            errors++;
            $error("[TB] FAIL %s code: observed=%0d expected=%0d", tag, fault_code, expCode);
        end
    endtask

    // Pulse reset mid-cycle, check the asynchronous reset values, then run the three INIT cycles.
    task automatic resetAndInit(input string tag, input logic [5:0] initPattern);
        rst = 1'b1;
        #1;
        checkOutput({tag, " in reset"}, RR, 1'b0, 3'd0);
        applyStimulus(initPattern);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkLamps({tag, " init"}, RR);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not reach the end of the sequence");
        $fatal(1, "[TB] time limit expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(RR);
        tick();
        checkOutput("reset", RR, 1'b0, 3'd0);
        rst = 1'b0;

        // Two full upstream periods: three INIT cycles of red/red, then one-cycle pass-through.
        applyStimulus(upstreamPattern(0));
        for (int c = 0; c < 152; c++) begin
            tick();
            checkLamps("passthrough", (c < 3) ? RR : upstreamPattern(c));
            applyStimulus(upstreamPattern(c + 1));
        end
        checkOutput("passthrough end", upstreamPattern(151), 1'b0, 3'd0);

        // Conflict: both greens for one cycle, then 4-on / 4-off flash with inputs ignored.
        applyStimulus(6'b001_001);
        tick();
        checkOutput("conflict entry", FLASH_ON, 1'b1, 3'd1);
        applyStimulus(6'b111_111);
        for (int k = 1; k < 12; k++) begin
            tick();
            checkLamps("flash", (((k / 4) % 2) == 0) ? FLASH_ON : DARK);
        end
        checkOutput("fault held", FLASH_ON, 1'b1, 3'd1);

        // Reset during the flash, INIT with green1 held, then pass-through resumes.
        resetAndInit("reset in fault", G1R2);
        tick();
        checkOutput("resume green", G1R2, 1'b0, 3'd0);
        applyStimulus(Y1R2);
        tick();
        checkOutput("resume yellow", Y1R2, 1'b0, 3'd0);

        // Invalid pattern, then conflict winning over a simultaneous invalid pattern.
        resetAndInit("invalid", RR);
        applyStimulus(6'b110_100);
        tick();
        checkOutput("invalid red+yellow", FLASH_ON, 1'b1, 3'd2);
        resetAndInit("priority", RR);
        applyStimulus(6'b101_001);
        tick();
        checkOutput("conflict priority", FLASH_ON, 1'b1, 3'd1);

        // Clearance: two all-red cycles are too few, three are enough.
        resetAndInit("clear short", RR);
        applyStimulus(G1R2); tick(); checkLamps("clear short g", G1R2);
        applyStimulus(Y1R2); tick(); checkLamps("clear short y", Y1R2);
        applyStimulus(RR);   tick(); checkLamps("clear short rr1", RR);
        tick(); checkOutput("clear short rr2", RR, 1'b0, 3'd0);
        applyStimulus(G1R2); tick();
        checkOutput("clearance violation", FLASH_ON, 1'b1, 3'd3);

        resetAndInit("clear ok", RR);
        applyStimulus(G1R2); tick(); checkLamps("clear ok g", G1R2);
        applyStimulus(Y1R2); tick(); checkLamps("clear ok y", Y1R2);
        applyStimulus(RR);
        for (int i = 0; i < 3; i++) tick();
        applyStimulus(G1R2); tick();
        checkOutput("clearance met", G1R2, 1'b0, 3'd0);

        // Watchdog: 100 unchanged MONITOR cycles faults; 99 then a change does not.
        resetAndInit("watchdog", RR);
        for (int i = 0; i < 99; i++) tick();
        checkOutput("watchdog 99", RR, 1'b0, 3'd0);
        tick();
        checkOutput("watchdog 100", FLASH_ON, 1'b1, 3'd4);

        resetAndInit("watchdog change", RR);
        for (int i = 0; i < 99; i++) tick();
        applyStimulus(G1R2);
        tick();
        checkOutput("watchdog change", G1R2, 1'b0, 3'd0);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("watchdog restarted", G1R2, 1'b0, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_lamp_monitor.md
TRAFFIC_LAMP_MONITOR -- requirements
Module: traffic_lamp_monitor

Interface
REQ-001 Parameter MIN_CLEAR_CYCLES, default 48, minimum consecutive all-red cycles required before any green onset; also the INIT duration.
REQ-002 Parameter WATCHDOG_CYCLES, default 1_600_000_000, cycles without any input-pattern change that trigger a stuck fault.
REQ-003 Parameter BLINK_CYCLES, default 8_000_000, half-period of the fault flash (0.5 s at 16 MHz).
REQ-004 clk  input  1  system clock, 16 MHz, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 red1, yellow1, green1, red2, yellow2, green2  input  1 each  lamp requests from the upstream traffic_light controller.
REQ-007 lamp_red1, lamp_yellow1, lamp_green1, lamp_red2, lamp_yellow2, lamp_green2  output  1 each  registered lamp drives.
REQ-008 fault  output  1  latched fault indicator.
REQ-009 fault_code  output  3  latched cause: 0 none, 1 conflict, 2 invalid pattern, 3 clearance violation, 4 watchdog.

Function
REQ-010 The block SHALL implement three states: INIT, MONITOR and FAULT.
REQ-011 In INIT, lamps SHALL drive red1/red2 = 1 and all others 0; checks are disabled; the block moves to MONITOR after MIN_CLEAR_CYCLES cycles.
REQ-012 In MONITOR, each lamp_* output SHALL equal the corresponding input delayed by exactly one clock.
REQ-013 Conflict (code 1): any of yellow/green asserted on direction 1 and any of yellow/green asserted on direction 2 in the same cycle.
REQ-014 Invalid pattern (code 2): a direction with zero or more than one of red/yellow/green asserted.
REQ-015 Clearance (code 3): green1 or green2 rising (0 in previous cycle, 1 now) while the consecutive all-red count ending in the previous cycle is below MIN_CLEAR_CYCLES.
REQ-016 The all-red counter SHALL saturate at MIN_CLEAR_CYCLES and clear on any cycle with red1 & red2 not both high.
REQ-017 Watchdog (code 4): input pattern unchanged for WATCHDOG_CYCLES consecutive MONITOR cycles; the counter clears on any pattern change and on entry to MONITOR.
REQ-018 Previous-input registers SHALL track inputs in INIT and MONITOR, so patterns held across INIT do not count as rises.
REQ-019 Detection SHALL be combinational on the current inputs; on the next edge state = FAULT, fault = 1, fault_code set, so an offending pattern never reaches lamp_*.
REQ-020 Simultaneous faults SHALL latch the lowest code.
REQ-021 In FAULT, lamp_red*/lamp_green* SHALL be 0 and lamp_yellow1 = lamp_yellow2 = blink; blink SHALL be 1 for the first BLINK_CYCLES cycles after entry, then toggle every BLINK_CYCLES cycles.
REQ-022 FAULT, fault and fault_code SHALL be held until rst; inputs are ignored in FAULT.

Reset
REQ-023 On rst assertion (asynchronous): state INIT, lamp_red1 = lamp_red2 = 1, all other lamps 0, fault = 0, fault_code = 0, all counters and previous-input registers 0.
REQ-024 Reset asserted mid-FAULT or mid-MONITOR SHALL apply REQ-023 immediately, and INIT SHALL restart in full after release.

Structure
REQ-025 State encoding, fault-code constants and the lamp-vector bit ordering SHALL live in a shared package traffic_pkg.
REQ-026 The flash generator SHALL be a sub-module traffic_blinker (enable, BLINK_CYCLES parameter, blink output); all else is in one module.

Verification (bench defparams: MIN_CLEAR_CYCLES=3, WATCHDOG_CYCLES=100, BLINK_CYCLES=4)
REQ-027 Upstream traffic_light (GREEN 30, YELLOW 5, RED_RED 3) feeding the block over two full periods -> 3 all-red INIT cycles, then lamps = inputs delayed 1 cycle, fault stays 0.
REQ-028 Force green1 = green2 = 1 for one cycle -> next edge fault = 1, code 1, lamp greens/reds 0, yellows 4 cycles on / 4 off, repeating.
REQ-029 Drive red1 = yellow1 = 1 -> code 2; also green1 = green2 = red1 = 1 simultaneously -> code 1 (priority).
REQ-030 All-red for 2 cycles then green1 -> code 3; all-red for 3 cycles then green1 -> no fault.
REQ-031 Hold one legal pattern for 100 MONITOR cycles -> fault = 1, code 4 on the 100th cycle; 99 cycles then a change -> no fault.
REQ-032 Assert rst during FAULT flash -> same-cycle lamps red/red, fault = 0, code 0; after release, 3 INIT cycles then pass-through resumes.
